// File: rtl/nonce_scheduler.sv
// nonce_scheduler: walks a nonce range through the double-SHA-256 core, one
// header per nonce, and stops on the first hash <= target, range end, abort or core timeout.
module nonce_scheduler #(
  parameter int TIMEOUT = 1024
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         start,
  input  logic         abort,
  input  logic [639:0] block_header,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [255:0] target,
  output logic         sha_start,
  output logic [639:0] sha_header,
  input  logic         sha_done,
  input  logic [255:0] sha_hash,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic         error,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic [31:0]  hash_count,
  output logic         led,
  output logic [2:0]   state_dbg
);

  // Handshake: start/abort/sha_done are single-cycle strobes with no back-pressure.
  // sha_start is high for exactly one cycle per nonce; the core answers with one
  // sha_done strobe, and sha_hash is only meaningful in that cycle.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT      = 3'd2,
    S_CHECK     = 3'd3,
    S_FOUND     = 3'd4,
    S_EXHAUSTED = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [31:0]     nonce_q, nonce_d;
  logic [31:0]     nonce_end_q, nonce_end_d;
  logic [255:0]    target_q, target_d;
  logic [255:0]    hash_q, hash_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            sha_start_q, sha_start_d;
  logic [639:0]    sha_header_q, sha_header_d;
  logic            busy_q, busy_d;
  logic            found_q, found_d;
  logic            exhausted_q, exhausted_d;
  logic            error_q, error_d;
  logic [31:0]     found_nonce_q, found_nonce_d;
  logic [255:0]    found_hash_q, found_hash_d;
  logic [31:0]     hash_count_q, hash_count_d;

  // The nonce slot of the incoming header is replaced by the scheduler's own nonce.
  logic unused_nonce_slot;
  assign unused_nonce_slot = ^block_header[31:0];

  always_comb begin
    state_d       = state_q;
    nonce_d       = nonce_q;
    nonce_end_d   = nonce_end_q;
    target_d      = target_q;
    hash_d        = hash_q;
    wd_d          = wd_q;
    sha_header_d  = sha_header_q;
    found_d       = found_q;
    exhausted_d   = exhausted_q;
    error_d       = error_q;
    found_nonce_d = found_nonce_q;
    found_hash_d  = found_hash_q;
    hash_count_d  = hash_count_q;

    if (abort) begin
      // Abort outranks everything, including a same-cycle start or sha_done.
      state_d     = S_IDLE;
      found_d     = 1'b0;
      exhausted_d = 1'b0;
      error_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_FOUND, S_EXHAUSTED, S_ERROR: begin
          if (start) begin
            sha_header_d  = {block_header[639:32], nonce_start};
            nonce_d       = nonce_start;
            nonce_end_d   = nonce_end;
            target_d      = target;
            found_d       = 1'b0;
            exhausted_d   = 1'b0;
            error_d       = 1'b0;
            hash_count_d  = '0;
            found_nonce_d = '0;
            found_hash_d  = '0;
            state_d       = S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd_d    = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (sha_done) begin
            hash_d = sha_hash;
            if (hash_count_q != 32'hFFFF_FFFF) begin
              hash_count_d = hash_count_q + 32'd1;
            end
            state_d = S_CHECK;
          end else if (wd_q == WD_LAST) begin
            error_d = 1'b1;
            state_d = S_ERROR;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (hash_q <= target_q) begin
            found_d       = 1'b1;
            found_nonce_d = nonce_q;
            found_hash_d  = hash_q;
            state_d       = S_FOUND;
          end else if (nonce_q == nonce_end_q) begin
            exhausted_d = 1'b1;
            state_d     = S_EXHAUSTED;
          end else begin
            // Natural 32-bit wrap lets a sweep cross 0xFFFFFFFF -> 0.
            nonce_d            = nonce_q + 32'd1;
            sha_header_d[31:0] = nonce_q + 32'd1;
            state_d            = S_ISSUE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    sha_start_d = (state_d == S_ISSUE);
    busy_d      = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_CHECK);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      nonce_q       <= '0;
      nonce_end_q   <= '0;
      target_q      <= '0;
      hash_q        <= '0;
      wd_q          <= '0;
      sha_start_q   <= 1'b0;
      sha_header_q  <= '0;
      busy_q        <= 1'b0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      error_q       <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
      hash_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      nonce_q       <= nonce_d;
      nonce_end_q   <= nonce_end_d;
      target_q      <= target_d;
      hash_q        <= hash_d;
      wd_q          <= wd_d;
      sha_start_q   <= sha_start_d;
      sha_header_q  <= sha_header_d;
      busy_q        <= busy_d;
      found_q       <= found_d;
      exhausted_q   <= exhausted_d;
      error_q       <= error_d;
      found_nonce_q <= found_nonce_d;
      found_hash_q  <= found_hash_d;
      hash_count_q  <= hash_count_d;
    end
  end

  assign sha_start   = sha_start_q;
  assign sha_header  = sha_header_q;
  assign busy        = busy_q;
  assign found       = found_q;
  assign exhausted   = exhausted_q;
  assign error       = error_q;
  assign found_nonce = found_nonce_q;
  assign found_hash  = found_hash_q;
  assign hash_count  = hash_count_q;
  assign led         = found_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Self-checking bench for nonce_scheduler: behavioural hash core plus a job-level
// reference model that predicts the issued nonce sequence and the job outcome.
module tb_nonce_scheduler;

  localparam int TIMEOUT = 16;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [639:0] block_header = '0;
  logic [31:0]  nonce_start = '0;
  logic [31:0]  nonce_end = '0;
  logic [255:0] target = '0;
  logic         sha_done = 1'b0;
  logic [255:0] sha_hash = '0;
  logic         sha_start;
  logic [639:0] sha_header;
  logic         busy, found, exhausted, error, led;
  logic [31:0]  found_nonce, hash_count;
  logic [255:0] found_hash;
  logic [2:0]   state_dbg;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];

  // behavioural core controls
  int          core_lat = 4;
  bit          core_mute = 1'b0;
  int          core_cnt = 0;
  logic [31:0] core_nonce = '0;
  int          done_cyc = 0;
  int          inject_req = 0;
  int          inject_ack = 0;
  int          hash_mode = 0;
  logic [31:0] hit_nonce = '0;
  logic [31:0] salt = '0;

  nonce_scheduler #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .resetn(resetn), .start(start), .abort(abort),
    .block_header(block_header), .nonce_start(nonce_start), .nonce_end(nonce_end),
    .target(target), .sha_start(sha_start), .sha_header(sha_header),
    .sha_done(sha_done), .sha_hash(sha_hash), .busy(busy), .found(found),
    .exhausted(exhausted), .error(error), .found_nonce(found_nonce),
    .found_hash(found_hash), .hash_count(hash_count), .led(led), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d want < 50000", cyc);
    $fatal(1);
  end

  // Mode 0: one hit nonce hashes to zero, all others to all-ones. Mode 1: pseudo-random.
  function automatic logic [255:0] core_hash(input logic [31:0] n);
    logic [31:0] w;
    if (hash_mode == 0) return (n == hit_nonce) ? {256{1'b0}} : {256{1'b1}};
    w = (n * 32'h9E37_79B1) ^ salt;
    return {w, {7{w ^ 32'h5bd1_e995}}};
  endfunction

  function automatic logic [639:0] rand_hdr();
    logic [639:0] h;
    for (int i = 0; i < 20; i++) h[i*32 +: 32] = $urandom();
    return h;
  endfunction

  // behavioural hash core: sha_done L cycles after the sha_start cycle
  always @(negedge clock) begin
    sha_done = 1'b0;
    if (inject_req != inject_ack) begin
      inject_ack = inject_ack + 1;
      sha_done   = 1'b1;
      sha_hash   = '0;
    end else if (core_cnt > 0) begin
      core_cnt = core_cnt - 1;
      if (core_cnt == 0) begin
        sha_done = 1'b1;
        sha_hash = core_hash(core_nonce);
        done_cyc = cyc;
      end
    end
    if (sha_start === 1'b1 && !core_mute) begin
      core_cnt   = core_lat;
      core_nonce = sha_header[31:0];
    end
  end

  // driver: launch a job and run it to completion against the reference model
  task automatic run_job(input logic [639:0] hdr, input logic [31:0] ns, input logic [31:0] ne,
                         input logic [255:0] tgt, input int lat, input bit poke);
    logic [31:0]  n, exp_nonce, got_n;
    logic [255:0] exp_hash;
    bit           exp_found;
    int           exp_cnt, issued, last_cyc, budget;
    exp_q.delete();
    n = ns; exp_found = 1'b0; exp_nonce = '0; exp_hash = '0;
    for (int k = 0; k < 4096; k++) begin
      exp_q.push_back(n);
      if (core_hash(n) <= tgt) begin
        exp_found = 1'b1; exp_nonce = n; exp_hash = core_hash(n);
        break;
      end
      if (n == ne) break;
      n = n + 32'd1;
    end
    exp_cnt = exp_q.size();

    core_lat = lat; core_mute = 1'b0;
    @(negedge clock);
    block_header = hdr; nonce_start = ns; nonce_end = ne; target = tgt; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    block_header = rand_hdr(); nonce_start = $urandom(); nonce_end = $urandom(); target = '0;
    vectors++;
    if (sha_start !== 1'b1) begin
      miscompares++; $display("FAIL start_latency: got sha_start=%b want 1", sha_start);
    end

    issued = 0; last_cyc = 0; budget = 0;
    while (!(found === 1'b1 || exhausted === 1'b1 || error === 1'b1) && budget < 2000) begin
      start = 1'b0;
      if (sha_start === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL extra_issue: got nonce %h want none", sha_header[31:0]);
        end else begin
          got_n = exp_q.pop_front();
          if (sha_header !== {hdr[639:32], got_n}) begin
            miscompares++;
            $display("FAIL issue_header: got nonce %h hdr_hi_ok=%b want nonce %h",
                     sha_header[31:0], sha_header[639:32] === hdr[639:32], got_n);
          end
        end
        if (issued > 0) begin
          vectors++;
          if (cyc - last_cyc != lat + 2) begin
            miscompares++; $display("FAIL period: got %0d want %0d", cyc - last_cyc, lat + 2);
          end
        end
        last_cyc = cyc; issued++;
        if (poke && issued == 2) begin
          nonce_start = ns + 32'd100; nonce_end = ns + 32'd200; target = '1; start = 1'b1;
        end
      end
      @(negedge clock); budget++;
    end
    start = 1'b0;

    vectors++;
    if (budget >= 2000) begin
      miscompares++; $display("FAIL job_budget: got %0d cycles want < 2000", budget);
    end
    vectors++;
    if (cyc != done_cyc + 2) begin
      miscompares++; $display("FAIL end_latency: got %0d cycles after done want 2", cyc - done_cyc);
    end
    vectors++;
    if ({found, led, exhausted, error, busy} !== {exp_found, exp_found, !exp_found, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL job_flags: got f=%b led=%b ex=%b err=%b busy=%b want f=%b led=%b ex=%b err=0 busy=0",
               found, led, exhausted, error, busy, exp_found, exp_found, !exp_found);
    end
    vectors++;
    if (found_nonce !== exp_nonce || found_hash !== exp_hash) begin
      miscompares++;
      $display("FAIL found_regs: got nonce %h hash %h want nonce %h hash %h",
               found_nonce, found_hash, exp_nonce, exp_hash);
    end
    vectors++;
    if (hash_count !== exp_cnt || issued != exp_cnt || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL job_count: got hash_count %0d issued %0d left %0d want %0d %0d 0",
               hash_count, issued, exp_q.size(), exp_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if ({sha_start, busy, found, exhausted, error, led} !== 6'b0 || state_dbg !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b state %0d want 000000 state 0",
               {sha_start, busy, found, exhausted, error, led}, state_dbg);
    end
    vectors++;
    if (sha_header !== '0 || found_nonce !== '0 || found_hash !== '0 || hash_count !== '0) begin
      miscompares++; $display("FAIL reset_regs: got hdr_lo %h cnt %0d want 0 0", sha_header[31:0], hash_count);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    vectors++;
    if (busy !== 1'b0 || sha_start !== 1'b0) begin
      miscompares++; $display("FAIL reset_release: got busy %b sha_start %b want 0 0", busy, sha_start);
    end
  endtask

  task automatic test_reset_mid_wait();
    core_mute = 1'b1;
    @(negedge clock);
    block_header = rand_hdr(); nonce_start = 32'h0000_1000; nonce_end = 32'h0000_1008;
    target = '0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL midwait_pre: got busy %b want 1", busy);
    end
    resetn = 1'b0;
    #1;
    vectors++;
    if ({sha_start, busy, found, exhausted, error, led} !== 6'b0 || state_dbg !== 3'd0 ||
        sha_header !== '0 || hash_count !== '0) begin
      miscompares++;
      $display("FAIL midwait_reset: got flags %b state %0d hdr_lo %h want 0 0 0",
               {sha_start, busy, found, exhausted, error, led}, state_dbg, sha_header[31:0]);
    end
    @(negedge clock);
    resetn = 1'b1;
    inject_req = inject_req + 1;
    repeat (4) @(negedge clock);
    vectors++;
    if (busy !== 1'b0 || hash_count !== '0 || found !== 1'b0 || state_dbg !== 3'd0) begin
      miscompares++;
      $display("FAIL post_reset_done: got busy %b cnt %0d found %b state %0d want 0 0 0 0",
               busy, hash_count, found, state_dbg);
    end
    core_mute = 1'b0;
  endtask

  task automatic test_single_hit();
    logic [639:0] hdr;
    hash_mode = 0; hit_nonce = 32'h42a1_4695;
    hdr = rand_hdr();
    hdr[639:608] = 32'h0100_0000;
    hdr[31:0]    = 32'h42a1_4695;
    run_job(hdr, 32'h42a1_4690, 32'h42a1_46A0, {72'h00000000000044b9f2, 184'h0}, 4, 1'b0);
    vectors++;
    if (found !== 1'b1 || led !== 1'b1 || found_nonce !== 32'h42a1_4695 || hash_count !== 32'd6) begin
      miscompares++;
      $display("FAIL single_hit: got found %b led %b nonce %h cnt %0d want 1 1 42a14695 6",
               found, led, found_nonce, hash_count);
    end
  endtask

  task automatic test_exhaust();
    hash_mode = 0; hit_nonce = 32'hDEAD_0000;
    run_job(rand_hdr(), 32'h10, 32'h13, '0, $urandom_range(1, 5), 1'b0);
    vectors++;
    if (exhausted !== 1'b1 || found !== 1'b0 || hash_count !== 32'd4) begin
      miscompares++;
      $display("FAIL exhaust: got ex %b found %b cnt %0d want 1 0 4", exhausted, found, hash_count);
    end
  endtask

  task automatic test_wrap();
    hash_mode = 0; hit_nonce = 32'h8000_0000;
    run_job(rand_hdr(), 32'hFFFF_FFFE, 32'h0000_0001, '0, $urandom_range(1, 5), 1'b0);
    vectors++;
    if (exhausted !== 1'b1 || hash_count !== 32'd4) begin
      miscompares++; $display("FAIL wrap: got ex %b cnt %0d want 1 4", exhausted, hash_count);
    end
  endtask

  // one-nonce range whose hash equals the target exactly
  task automatic test_single_equal();
    hash_mode = 0; hit_nonce = 32'h0000_0777;
    run_job(rand_hdr(), 32'h0000_0777, 32'h0000_0777, '0, 1, 1'b0);
    vectors++;
    if (found !== 1'b1 || hash_count !== 32'd1 || found_nonce !== 32'h0000_0777) begin
      miscompares++;
      $display("FAIL single_equal: got found %b cnt %0d nonce %h want 1 1 00000777",
               found, hash_count, found_nonce);
    end
  endtask

  task automatic test_timeout();
    int seen;
    core_mute = 1'b1;
    @(negedge clock);
    block_header = rand_hdr(); nonce_start = 32'h55; nonce_end = 32'h60; target = '0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    vectors++;
    if (sha_start !== 1'b1) begin
      miscompares++; $display("FAIL timeout_issue: got sha_start %b want 1", sha_start);
    end
    repeat (16) @(negedge clock);
    vectors++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      miscompares++; $display("FAIL timeout_early: got error %b busy %b want 0 1", error, busy);
    end
    @(negedge clock);
    vectors++;
    if (error !== 1'b1 || busy !== 1'b0 || found !== 1'b0 || exhausted !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_edge: got error %b busy %b found %b ex %b want 1 0 0 0",
               error, busy, found, exhausted);
    end
    inject_req = inject_req + 1;
    seen = 0;
    repeat (4) begin
      @(negedge clock);
      if (sha_start === 1'b1) seen++;
    end
    vectors++;
    if (error !== 1'b1 || found !== 1'b0 || hash_count !== '0 || seen != 0) begin
      miscompares++;
      $display("FAIL late_done: got error %b found %b cnt %0d issues %0d want 1 0 0 0",
               error, found, hash_count, seen);
    end
    core_mute = 1'b0;
  endtask

  task automatic test_abort_wait();
    int seen;
    hash_mode = 0; hit_nonce = 32'h0; core_mute = 1'b0; core_lat = 4;
    @(negedge clock);
    block_header = rand_hdr(); nonce_start = 32'h100; nonce_end = 32'h1FF; target = '0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || sha_start !== 1'b0 || state_dbg !== 3'd0 || hash_count !== '0) begin
      miscompares++;
      $display("FAIL abort_wait: got busy %b sha_start %b state %0d cnt %0d want 0 0 0 0",
               busy, sha_start, state_dbg, hash_count);
    end
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (sha_start === 1'b1) seen++;
    end
    vectors++;
    if (hash_count !== '0 || busy !== 1'b0 || seen != 0 || found !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_late_done: got cnt %0d busy %b issues %0d found %b want 0 0 0 0",
               hash_count, busy, seen, found);
    end
  endtask

  task automatic test_abort_collisions();
    int seen;
    hash_mode = 0; hit_nonce = 32'h0000_0300;
    run_job(rand_hdr(), 32'h0000_02FE, 32'h0000_0310, '0, 2, 1'b0);
    @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    vectors++;
    if (found !== 1'b0 || led !== 1'b0 || exhausted !== 1'b0 || error !== 1'b0 || state_dbg !== 3'd0) begin
      miscompares++;
      $display("FAIL abort_found: got found %b led %b ex %b err %b state %0d want 0 0 0 0 0",
               found, led, exhausted, error, state_dbg);
    end
    run_job(rand_hdr(), 32'h0000_0300, 32'h0000_0300, '0, 3, 1'b0);
    for (int r = 0; r < 2; r++) begin
      @(negedge clock);
      block_header = rand_hdr(); nonce_start = 32'h0000_0300; nonce_end = 32'h0000_0310;
      start = 1'b1; abort = 1'b1;
      @(negedge clock);
      start = 1'b0; abort = 1'b0;
      seen = 0;
      repeat (3) begin
        if (sha_start === 1'b1) seen++;
        @(negedge clock);
      end
      vectors++;
      if (busy !== 1'b0 || found !== 1'b0 || state_dbg !== 3'd0 || seen != 0) begin
        miscompares++;
        $display("FAIL start_abort_%0d: got busy %b found %b state %0d issues %0d want 0 0 0 0",
                 r, busy, found, state_dbg, seen);
      end
    end
  endtask

  task automatic test_random_jobs();
    logic [31:0]  ns, len;
    logic [255:0] tgt;
    hash_mode = 1;
    for (int j = 0; j < 14; j++) begin
      salt = $urandom();
      len  = $urandom_range(1, 8);
      ns   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 4) : $urandom();
      tgt[255:224] = $urandom() >> 2;
      for (int w = 0; w < 7; w++) tgt[w*32 +: 32] = $urandom();
      if (j == 5) tgt = '1;
      if (j == 6) tgt = '0;
      run_job(rand_hdr(), ns, ns + len - 32'd1, tgt, $urandom_range(1, 5), ($urandom_range(0, 1) == 1));
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_reset_mid_wait();
    test_exhaust();
    test_wrap();
    test_single_equal();
    test_timeout();
    test_abort_wait();
    test_abort_collisions();
    test_random_jobs();
    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
